regfile_sb: RTL

- Parametrised integer register file for the NPC core: 2^AW entries, DW wide, NREAD combinational read ports, one synchronous write port.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard, so decode can detect RAW hazards against in-flight producers.
- Sits between decode (read/issue) and writeback (write/clear).
- Drives an architectural tap of one register (a0 by default) for the simulation exit/trap check.

---
 rtl/regfile_sb_pkg.sv | 19 +
 rtl/regfile_sb_if.sv | 39 +++
 rtl/regfile_sb_scoreboard.sv | 66 ++++++
 rtl/regfile_sb.sv | 73 +++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the regfile_sb slice.
// Holds the default geometry (DW/AW/NREAD), the hardwired-zero register
// index, the architectural a0 index used as the default tap, and a helper
// that locates one port's field inside a packed multi-port vector.
package regfile_sb_pkg;

  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_AW    = 5;
  localparam int unsigned DEF_NREAD = 2;
  localparam int unsigned ZERO_REG  = 0;
  localparam int unsigned A0_IDX    = 10;

  // LSB position of field `port` in a vector of `width`-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port,
                                           input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file.
// master: the pipeline side (drives read addresses, issue and writeback).
// slave : the register file (returns read data, per-port busy and hazard).
//   rs_addr   NREAD*AW  read addresses, port i at [i*AW +: AW]
//   rs_data   NREAD*DW  read data, port i at [i*DW +: DW]
//   rs_busy   NREAD     port i's register has a pending producer
//   hazard    1         OR of rs_busy
//   iss_valid 1         an instruction writing iss_rd issues this cycle
//   iss_rd    AW        destination of the issuing instruction
//   wen/waddr/wdata     writeback port
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned NREAD = DEF_NREAD
);

  logic [NREAD*AW-1:0] rs_addr;
  logic [NREAD*DW-1:0] rs_data;
  logic [NREAD-1:0]    rs_busy;
  logic                hazard;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                wen;
  logic [AW-1:0]       waddr;
  logic [DW-1:0]       wdata;

  modport master (
    output rs_addr, iss_valid, iss_rd, wen, waddr, wdata,
    input  rs_data, rs_busy, hazard
  );

  modport slave (
    input  rs_addr, iss_valid, iss_rd, wen, waddr, wdata,
    output rs_data, rs_busy, hazard
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard.
// A bit is set when a producer for that register issues and cleared when
// writeback lands. Register 0 never becomes busy.
//   clk, rst          clock, asynchronous active-low reset
//   iss_valid/iss_rd  issue (set) request
//   wen/waddr         writeback (clear) request
//   rs_addr           packed read addresses to look up
//   rs_busy           per-port busy, suppressed when the value is forwarded
//   hazard            OR of rs_busy
//   busy_vec          raw scoreboard
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned NREAD = DEF_NREAD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD-1:0]      rs_busy,
  output logic                  hazard,
  output logic [(1<<AW)-1:0]    busy_vec
);

  logic [(1<<AW)-1:0] busy;
  logic [(1<<AW)-1:0] busy_next;
  logic [AW-1:0]      port_addr;

  // Clear is applied before set so that a new producer issuing to the
  // register being written back keeps it busy.
  always_comb begin
    busy_next = busy;
    if (wen && (waddr != AW'(ZERO_REG)))
      busy_next[waddr] = 1'b0;
    if (iss_valid && (iss_rd != AW'(ZERO_REG)))
      busy_next[iss_rd] = 1'b1;
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy <= '0;
    else
      busy <= busy_next;
  end

  // A register written this cycle is forwarded by the bypass, so it is not
  // reported as a hazard even though its busy bit is still set.
  always_comb begin
    rs_busy   = '0;
    port_addr = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      port_addr  = rs_addr[port_lsb(i, AW) +: AW];
      rs_busy[i] = (port_addr != AW'(ZERO_REG)) && busy[port_addr] &&
                   !(wen && (waddr == port_addr));
    end
  end

  assign hazard   = |rs_busy;
  assign busy_vec = busy;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass and busy scoreboard.
// 2^AW entries of DW bits, entry 0 hardwired to zero, NREAD combinational
// read ports, one synchronous write port.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        decode/writeback bus (slave side)
//   busy_vec   raw scoreboard, bit 0 always 0
//   tap_value  stored value of register TAP_IDX (no bypass)
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned NREAD   = DEF_NREAD,
  parameter int unsigned TAP_IDX = A0_IDX
) (
  input  logic               clk,
  input  logic               rst,
  regfile_sb_if.slave        bus,
  output logic [(1<<AW)-1:0] busy_vec,
  output logic [DW-1:0]      tap_value
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] regs [DEPTH];
  logic [AW-1:0] rd_addr [NREAD];
  logic          write_en;

  assign write_en = bus.wen && (bus.waddr != AW'(ZERO_REG));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (write_en) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    rd_addr     = '{default: '0};
    bus.rs_data = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      rd_addr[i] = bus.rs_addr[port_lsb(i, AW) +: AW];
      if (rd_addr[i] == AW'(ZERO_REG))
        bus.rs_data[port_lsb(i, DW) +: DW] = '0;
      else if (bus.wen && (bus.waddr == rd_addr[i]))
        bus.rs_data[port_lsb(i, DW) +: DW] = bus.wdata;
      else
        bus.rs_data[port_lsb(i, DW) +: DW] = regs[rd_addr[i]];
    end
  end

  regfile_sb_scoreboard #(
    .AW    (AW),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .wen       (bus.wen),
    .waddr     (bus.waddr),
    .rs_addr   (bus.rs_addr),
    .rs_busy   (bus.rs_busy),
    .hazard    (bus.hazard),
    .busy_vec  (busy_vec)
  );

  assign tap_value = regs[TAP_IDX];

endmodule
